// File: rtl/regwrite_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   XLEN_DEF    default data width
//   REG_ADDR_W  register address width (x0..x31)
//   NUM_REGS    number of architectural registers
//   gnt_e       write-port grant: none, pipeline writeback, or MulDiv FIFO head
//   rd_onehot   decodes a register address into a one-hot register mask
package regwrite_arbiter_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MD   = 2'd2
  } gnt_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Bundle of the write-port arbiter's bus signals.
//   master : pipeline writeback + MulDiv producers, regfile/decode consumers (testbench side)
//   slave  : the arbiter itself
//   wb_*       writeback request (wb_stall back-pressure)
//   md_*       MulDiv result handshake (md_ready back-pressure)
//   rf_*       registered regfile write port
//   pend_mask  registers with a result still in flight (FIFO or output register)
//   pend_count MulDiv FIFO occupancy
interface regwrite_arbiter_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) ();
  import regwrite_arbiter_pkg::*;

  logic                         wb_valid;
  logic [REG_ADDR_W-1:0]        wb_rd;
  logic [XLEN-1:0]              wb_data;
  logic                         wb_stall;
  logic                         md_valid;
  logic [REG_ADDR_W-1:0]        md_rd;
  logic [XLEN-1:0]              md_data;
  logic                         md_ready;
  logic                         rf_we;
  logic [REG_ADDR_W-1:0]        rf_rd;
  logic [XLEN-1:0]              rf_wdata;
  logic [NUM_REGS-1:0]          pend_mask;
  logic [$clog2(DEPTH+1)-1:0]   pend_count;

  modport master (
    output wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
    input  wb_stall, md_ready, rf_we, rf_rd, rf_wdata, pend_mask, pend_count
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
    output wb_stall, md_ready, rf_we, rf_rd, rf_wdata, pend_mask, pend_count
  );

endinterface

// File: rtl/regwrite_arbiter_fifo.sv
// Synchronous FIFO of {rd, data} MulDiv results.
//   clk, rst            clock, synchronous active-high reset (empties the FIFO)
//   push/push_rd/_data  write an entry (ignored when full)
//   pop                 retire the head entry (ignored when empty)
//   head_rd/head_data   current head entry
//   full/empty/count    occupancy status
//   entry_rd/entry_valid per-slot destination and occupancy, for the pending mask
module regwrite_arbiter_fifo
  import regwrite_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [REG_ADDR_W-1:0]       push_rd,
  input  logic [XLEN-1:0]             push_data,
  input  logic                        pop,
  output logic [REG_ADDR_W-1:0]       head_rd,
  output logic [XLEN-1:0]             head_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [REG_ADDR_W-1:0]       entry_rd [DEPTH],
  output logic [DEPTH-1:0]            entry_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH+1);

  // One extra pointer bit distinguishes full from empty; pointers wrap naturally.
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [REG_ADDR_W-1:0] mem_rd   [DEPTH];
  logic [XLEN-1:0]       mem_data [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign count   = CW'(wr_ptr - rd_ptr);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_rd   = mem_rd[rd_ptr[AW-1:0]];
  assign head_data = mem_data[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: slots are only observed through the valid vector.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_rd[wr_ptr[AW-1:0]]   <= push_rd;
      mem_data[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [AW-1:0] offs;
    assign offs           = AW'(i) - rd_ptr[AW-1:0];
    assign entry_rd[i]    = mem_rd[i];
    assign entry_valid[i] = (CW'(offs) < count);
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// Owns the single register-file write port, shared between the in-order
// writeback path and queued MulDiv results.
//   clk          clock, rising edge
//   rst          synchronous active-high reset; discards queued MulDiv results
//   bus (slave)  wb request/stall, md request/ready, registered rf write port,
//                pending-register mask and FIFO occupancy
// Writeback normally wins; a queued MulDiv result that has lost STARVE_LIMIT
// consecutive cycles forces a writeback stall so the FIFO can drain.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  regwrite_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [REG_ADDR_W-1:0] entry_rd [DEPTH];
  logic [DEPTH-1:0]      entry_valid;

  logic [SW-1:0]         starve_cnt;
  logic                  starve_hit;
  gnt_e                  gnt;
  logic [REG_ADDR_W-1:0] gnt_rd;
  logic [XLEN-1:0]       gnt_data;

  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_rd_q;
  logic [XLEN-1:0]       rf_wdata_q;
  logic [NUM_REGS-1:0]   mask;
  logic                  md_ready;

  regwrite_arbiter_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_rd     (bus.md_rd),
    .push_data   (bus.md_data),
    .pop         (fifo_pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  // No acceptance while reset is held, so a producer never believes a
  // result landed in a FIFO that is being cleared.
  assign md_ready  = !rst && !fifo_full;
  assign fifo_push = bus.md_valid && md_ready;

  assign starve_hit = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    gnt = GNT_NONE;
    if (!fifo_empty && (starve_hit || !bus.wb_valid)) gnt = GNT_MD;
    else if (bus.wb_valid)                            gnt = GNT_WB;
  end

  assign fifo_pop = (gnt == GNT_MD);
  assign gnt_rd   = (gnt == GNT_MD) ? head_rd   : bus.wb_rd;
  assign gnt_data = (gnt == GNT_MD) ? head_data : bus.wb_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!fifo_empty && gnt == GNT_WB) begin
      if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // x0 grants are still consumed/popped but never reach the regfile; the
  // address/data registers keep their last values so the port stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else if (gnt != GNT_NONE && gnt_rd != '0) begin
      rf_we_q    <= 1'b1;
      rf_rd_q    <= gnt_rd;
      rf_wdata_q <= gnt_data;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  // The output register counts as pending: decode sees the value in flight
  // until the regfile write has actually happened.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) mask = mask | rd_onehot(entry_rd[i]);
    end
    if (rf_we_q) mask = mask | rd_onehot(rf_rd_q);
    mask[0] = 1'b0;
  end

  assign bus.wb_stall   = starve_hit;
  assign bus.md_ready   = md_ready;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.pend_mask  = mask;
  assign bus.pend_count = fifo_count;

endmodule

// File: tb/tb_regwrite_arbiter.sv
module tb_regwrite_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   n_writes = 0;
  logic last_wb_acc = 1'b0;
  logic last_md_acc = 1'b0;
  wr_t  exp_q[$];

  regwrite_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  regwrite_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [63:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one clock; inputs are sampled at the edge, outputs checked 1 time unit later.
  task automatic tick();
    logic wb_acc;
    logic md_acc;
    wr_t  e;
    wb_acc = bus.wb_valid && !bus.wb_stall;
    md_acc = bus.md_valid && bus.md_ready;
    @(posedge clk);
    #1;
    last_wb_acc = wb_acc;
    last_md_acc = md_acc;
    if (bus.rf_we === 1'b1) begin
      n_writes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed rd %0d data %0h, expected no write",
               bus.rf_rd, bus.rf_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_rd", 64'(bus.rf_rd), 64'(e.rd));
        chk("wr_data", bus.rf_wdata, e.data);
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    int n_acc;
    bit seen_full;

    rst          = 1'b1;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.md_valid = 1'b1;
    bus.md_rd    = 5'd3;
    bus.md_data  = 64'h33;

    // 1: reset holds everything quiet, even with md_valid asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
      chk("rst_md_ready", 64'(bus.md_ready), 64'd0);
      chk("rst_pend_mask", 64'(bus.pend_mask), 64'd0);
    end
    rst          = 1'b0;
    bus.md_valid = 1'b0;
    #1;
    chk("rel_md_ready", 64'(bus.md_ready), 64'd1);
    chk("rel_wb_stall", 64'(bus.wb_stall), 64'd0);
    chk("rel_pend_count", 64'(bus.pend_count), 64'd0);

    // queue two entries behind x0 writebacks, then reset discards them
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd0;
    bus.md_valid = 1'b1;
    bus.md_rd    = 5'd10;
    bus.md_data  = 64'hA10;
    tick();
    bus.md_rd    = 5'd11;
    bus.md_data  = 64'hA11;
    tick();
    bus.md_valid = 1'b0;
    chk("q2_pend_count", 64'(bus.pend_count), 64'd2);
    chk("q2_pend_mask", 64'(bus.pend_mask), 64'h0000_0C00);
    rst = 1'b1;
    tick();
    chk("rst_q_pend_count", 64'(bus.pend_count), 64'd0);
    chk("rst_q_pend_mask", 64'(bus.pend_mask), 64'd0);
    rst          = 1'b0;
    bus.wb_valid = 1'b0;
    tick();
    tick();
    chk("rst_q_no_write", 64'(bus.rf_we), 64'd0);

    // 2: plain writeback, one-cycle latency
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 64'hDEAD;
    expect_wr(5'd5, 64'hDEAD);
    #1;
    chk("wb_stall_c", 64'(bus.wb_stall), 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    chk("wb_rf_we", 64'(bus.rf_we), 64'd1);
    chk("wb_stall_c1", 64'(bus.wb_stall), 64'd0);
    tick();
    chk("wb_rf_we_off", 64'(bus.rf_we), 64'd0);
    drain("wb_drain", 4);

    // 3: MulDiv result through an idle port, no bypass
    bus.md_valid = 1'b1;
    bus.md_rd    = 5'd7;
    bus.md_data  = 64'h1234;
    expect_wr(5'd7, 64'h1234);
    tick();
    bus.md_valid = 1'b0;
    chk("md_acc", 64'(last_md_acc), 64'd1);
    chk("md_pend7_q", 64'(bus.pend_mask[7]), 64'd1);
    chk("md_pend_count", 64'(bus.pend_count), 64'd1);
    chk("md_no_bypass", 64'(bus.rf_we), 64'd0);
    tick();
    chk("md_rf_we", 64'(bus.rf_we), 64'd1);
    chk("md_pend7_out", 64'(bus.pend_mask[7]), 64'd1);
    chk("md_pend_count0", 64'(bus.pend_count), 64'd0);
    tick();
    chk("md_pend7_clr", 64'(bus.pend_mask[7]), 64'd0);
    drain("md_drain", 4);

    // 4: starvation; wb W0 is granted alongside the push, then W1..W4 starve the
    //    FIFO, one stall cycle writes rd=9, and the held W5 follows
    for (int k = 0; k < 5; k++) expect_wr(5'(12 + k), 64'hA000 + 64'(k));
    expect_wr(5'd9, 64'h9999);
    expect_wr(5'd17, 64'hA005);
    w            = 0;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd12;
    bus.wb_data  = 64'hA000;
    bus.md_valid = 1'b1;
    bus.md_rd    = 5'd9;
    bus.md_data  = 64'h9999;
    #1;
    chk("st_stall_0", 64'(bus.wb_stall), 64'd0);
    tick();
    bus.md_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (last_wb_acc) begin
        w++;
        bus.wb_rd   = 5'(12 + w);
        bus.wb_data = 64'hA000 + 64'(w);
      end
      chk($sformatf("st_stall_%0d", c), 64'(bus.wb_stall), (c == 5) ? 64'd1 : 64'd0);
      tick();
    end
    bus.wb_valid = 1'b0;
    chk("st_wb_count", 64'(w + (last_wb_acc ? 1 : 0)), 64'd6);
    chk("st_stall_end", 64'(bus.wb_stall), 64'd0);
    drain("st_drain", 6);

    // 5: full FIFO back-pressure and ordering, behind continuous x0 writebacks
    expect_wr(5'd1, 64'hB1);
    expect_wr(5'd2, 64'hB2);
    expect_wr(5'd3, 64'hB3);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 64'h0;
    bus.md_valid = 1'b1;
    bus.md_rd    = 5'd1;
    bus.md_data  = 64'hB1;
    n_acc        = 0;
    seen_full    = 1'b0;
    for (int c = 0; c < 40 && n_acc < 3; c++) begin
      tick();
      if (last_md_acc) begin
        n_acc++;
        if (n_acc == 3) chk("full_drain_first", 64'(n_writes > 0 && exp_q.size() == 2), 64'd1);
        bus.md_rd   = 5'(n_acc + 1);
        bus.md_data = 64'hB0 + 64'(n_acc + 1);
        if (n_acc == 3) bus.md_valid = 1'b0;
      end
      if (n_acc == 2 && !seen_full) begin
        seen_full = 1'b1;
        chk("full_md_ready", 64'(bus.md_ready), 64'd0);
        chk("full_pend_count", 64'(bus.pend_count), 64'd2);
      end
    end
    chk("full_accepts", 64'(n_acc), 64'd3);
    bus.md_valid = 1'b0;
    drain("full_drain", 30);
    bus.wb_valid = 1'b0;
    tick();

    // 6: x0 from both sources is consumed and never written or marked pending
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 64'hC0;
    bus.md_valid = 1'b1;
    bus.md_rd    = 5'd0;
    bus.md_data  = 64'hC1;
    tick();
    bus.wb_valid = 1'b0;
    bus.md_valid = 1'b0;
    chk("x0_wb_acc", 64'(last_wb_acc), 64'd1);
    chk("x0_rf_we_a", 64'(bus.rf_we), 64'd0);
    chk("x0_pend_count1", 64'(bus.pend_count), 64'd1);
    chk("x0_pend_mask", 64'(bus.pend_mask), 64'd0);
    tick();
    chk("x0_pend_count0", 64'(bus.pend_count), 64'd0);
    chk("x0_rf_we_b", 64'(bus.rf_we), 64'd0);
    tick();
    chk("x0_rf_we_c", 64'(bus.rf_we), 64'd0);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
